// File: rtl/ram_be_clr.sv
// ram_be_clr: byte-enable single-port RAM with clear engine (in: clk reset cen wen be addr din clr; out: dout rvalid busy err)
module ram_be_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d, rdata, merged;
  logic              rvalid_q, rvalid_d, err_q, err_d;
  logic              in_range, acc, rd, wr, last;
  always_comb begin
    in_range = 32'(addr) < 32'(DEPTH);
    rdata    = mem[in_range ? addr : '0];
    merged   = rdata;
    for (int i = 0; i < NB; i++) merged[8*i+:8] = be[i] ? din[8*i+:8] : rdata[8*i+:8];
    last     = ptr_q == ADDR_W'(DEPTH - 1);
    acc      = state_q == IDLE && !clr && cen && in_range;
    rd       = acc && !wen;
    wr       = acc && wen;
    state_d  = state_q == CLEAR ? (last ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    ptr_d    = state_q == CLEAR ? ptr_q + 1'b1 : '0;
    dout_d   = (rd || (wr && RDW_MODE == 1)) ? rdata : (wr && RDW_MODE == 2) ? merged : '0;
    rvalid_d = rd || (wr && RDW_MODE != 0);
    err_d    = cen && (state_q == CLEAR || clr || !in_range);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state_q == CLEAR) mem[ptr_q] <= '0;
    else if (!reset && wr)
      for (int i = 0; i < NB; i++) if (be[i]) mem[addr][8*i+:8] <= din[8*i+:8];
  end
  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign busy   = state_q == CLEAR;
endmodule

// File: tb/tb_ram_be_clr.sv
// tb_ram_be_clr: directed scoreboard bench for ram_be_clr across RDW modes and a short-depth instance
module tb_ram_be_clr;
  logic        clk, reset, cen, wen, clr;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout_w [4];
  logic        rvalid_w [4];
  logic        busy_w [4];
  logic        err_w [4];
  int          checks = 0, failures = 0;
  typedef struct {int idx; string tag; logic [34:0] v;} exp_t;
  exp_t q[$];
  ram_be_clr #(.RDW_MODE(0)) d0 (.clk(clk), .reset(reset), .cen(cen), .wen(wen), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout_w[0]), .rvalid(rvalid_w[0]), .busy(busy_w[0]), .err(err_w[0]));
  ram_be_clr #(.RDW_MODE(1)) d1 (.clk(clk), .reset(reset), .cen(cen), .wen(wen), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout_w[1]), .rvalid(rvalid_w[1]), .busy(busy_w[1]), .err(err_w[1]));
  ram_be_clr #(.RDW_MODE(2)) d2 (.clk(clk), .reset(reset), .cen(cen), .wen(wen), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout_w[2]), .rvalid(rvalid_w[2]), .busy(busy_w[2]), .err(err_w[2]));
  ram_be_clr #(.DEPTH(24)) d3 (.clk(clk), .reset(reset), .cen(cen), .wen(wen), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout_w[3]), .rvalid(rvalid_w[3]), .busy(busy_w[3]), .err(err_w[3]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic drive(input logic c, input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] d, input logic cl);
    cen = c; wen = w; be = b; addr = a; din = d; clr = cl;
  endtask
  task automatic push(input int idx, input string tag, input logic [31:0] d, input logic rv, input logic e, input logic bz);
    exp_t x;
    x.idx = idx; x.tag = tag; x.v = {d, rv, e, bz};
    q.push_back(x);
  endtask
  task automatic tick();
    exp_t x;
    logic [34:0] obs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      obs = {dout_w[x.idx], rvalid_w[x.idx], err_w[x.idx], busy_w[x.idx]};
      checks++;
      assert (obs === x.v) else begin
        failures++;
        $error("FAIL %s dut%0d {dout,rvalid,err,busy} got=%h exp=%h", x.tag, x.idx, obs, x.v);
      end
    end
  endtask
  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask
  initial begin
    int n, n3;
    reset = 1'b1;
    drive(0, 0, 4'h0, 5'd0, 32'h0, 0);
    push(0, "reset_state", 32'h0, 0, 0, 1);
    push(3, "reset_state24", 32'h0, 0, 0, 1);
    tick();
    reset = 1'b0;
    n = 0; n3 = 0;
    while (busy_w[0] && n < 100) begin
      tick();
      n++;
      if (!busy_w[3] && n3 == 0) n3 = n;
    end
    check_int("busy_len_reset", n, 32);
    check_int("busy_len_reset24", n3, 24);
    for (int a = 0; a < 32; a++) begin
      drive(1, 0, 4'h0, 5'(a), 32'h0, 0);
      push(0, "clear_read", 32'h0, 1, 0, 0);
      if (a < 24) push(3, "clear_read24", 32'h0, 1, 0, 0);
      else push(3, "oor_read_sweep", 32'h0, 0, 1, 0);
      tick();
    end
    drive(1, 1, 4'hF, 5'd5, 32'h1122_3344, 0);
    push(0, "be_wr1_m0", 32'h0, 0, 0, 0);
    push(1, "be_wr1_m1", 32'h0, 1, 0, 0);
    push(2, "be_wr1_m2", 32'h1122_3344, 1, 0, 0);
    tick();
    drive(1, 1, 4'b0101, 5'd5, 32'hAABB_CCDD, 0);
    push(0, "be_wr2_m0", 32'h0, 0, 0, 0);
    push(1, "be_wr2_m1", 32'h1122_3344, 1, 0, 0);
    push(2, "be_wr2_m2", 32'h11BB_33DD, 1, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd5, 32'h0, 0);
    for (int i = 0; i < 3; i++) push(i, "be_merge_rd", 32'h11BB_33DD, 1, 0, 0);
    tick();
    drive(1, 1, 4'hF, 5'd3, 32'h0000_00FF, 0);
    tick();
    drive(1, 1, 4'hF, 5'd3, 32'h1234_5678, 0);
    push(0, "rdw_m0", 32'h0, 0, 0, 0);
    push(1, "rdw_m1", 32'h0000_00FF, 1, 0, 0);
    push(2, "rdw_m2", 32'h1234_5678, 1, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd3, 32'h0, 0);
    for (int i = 0; i < 3; i++) push(i, "rd_after_wr", 32'h1234_5678, 1, 0, 0);
    tick();
    drive(1, 1, 4'h0, 5'd3, 32'hFFFF_FFFF, 0);
    push(1, "be0_wr_m1", 32'h1234_5678, 1, 0, 0);
    push(2, "be0_wr_m2", 32'h1234_5678, 1, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd3, 32'h0, 0);
    push(0, "be0_rd", 32'h1234_5678, 1, 0, 0);
    tick();
    drive(0, 0, 4'h0, 5'd3, 32'h0, 0);
    push(0, "cen0_idle", 32'h0, 0, 0, 0);
    tick();
    drive(1, 1, 4'hF, 5'd30, 32'hCAFE_F00D, 0);
    push(3, "oor_wr", 32'h0, 0, 1, 0);
    push(0, "inrange_wr30", 32'h0, 0, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd30, 32'h0, 0);
    push(3, "oor_rd", 32'h0, 0, 1, 0);
    push(0, "inrange_rd30", 32'hCAFE_F00D, 1, 0, 0);
    tick();
    drive(1, 1, 4'hF, 5'd23, 32'h0000_0055, 0);
    push(3, "last_wr24", 32'h0, 0, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd23, 32'h0, 0);
    push(3, "last_rd24", 32'h0000_0055, 1, 0, 0);
    tick();
    drive(1, 1, 4'hF, 5'd7, 32'hDEAD_BEEF, 1);
    push(0, "clr_collide", 32'h0, 0, 1, 1);
    push(3, "clr_collide24", 32'h0, 0, 1, 1);
    tick();
    drive(0, 0, 4'h0, 5'd0, 32'h0, 0);
    push(0, "clr_err_once", 32'h0, 0, 0, 1);
    tick();
    n = 1; n3 = 0;
    while (busy_w[0] && n < 100) begin
      drive(n == 10, 0, 4'h0, 5'd0, 32'h0, n == 20);
      if (n == 10) push(0, "busy_access", 32'h0, 0, 1, 1);
      if (n == 11) push(0, "busy_err_once", 32'h0, 0, 0, 1);
      tick();
      n++;
      if (!busy_w[3] && n3 == 0) n3 = n;
    end
    check_int("busy_len_clr", n, 32);
    check_int("busy_len_clr24", n3, 24);
    drive(1, 0, 4'h0, 5'd7, 32'h0, 0);
    push(0, "clr_rd7", 32'h0, 1, 0, 0);
    tick();
    drive(1, 0, 4'h0, 5'd5, 32'h0, 0);
    push(2, "clr_rd5", 32'h0, 1, 0, 0);
    tick();
    drive(0, 0, 4'h0, 5'd0, 32'h0, 1);
    tick();
    drive(0, 0, 4'h0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 19; i++) tick();
    reset = 1'b1;
    drive(1, 1, 4'hF, 5'd9, 32'hFFFF_FFFF, 0);
    push(0, "mid_clear_reset", 32'h0, 0, 0, 1);
    tick();
    reset = 1'b0;
    drive(0, 0, 4'h0, 5'd0, 32'h0, 0);
    n = 0;
    while (busy_w[0] && n < 100) begin
      tick();
      n++;
    end
    check_int("busy_len_midreset", n, 32);
    drive(1, 0, 4'h0, 5'd9, 32'h0, 0);
    push(0, "reset_drop_rd9", 32'h0, 1, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
